alu_mc: RTL and testbench
=========================

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width (even, >=8).
REQ-002 SHALL have parameter OPCODE_LENGTH, default 5, Operation width.
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  block can accept a request.
REQ-007 SHALL have port SrcA, SrcB  input  DATA_WIDTH  operands.
REQ-008 SHALL have port Operation  input  OPCODE_LENGTH  operation select.
REQ-009 SHALL have port out_valid  output  1  ALUResult valid.
REQ-010 SHALL have port out_ready  input  1  consumer takes the result.
REQ-011 SHALL have port ALUResult  output  DATA_WIDTH  registered result.
REQ-012 SHALL have port busy  output  1  iterative mul/div in progress.

Function
REQ-013 Opcodes SHALL be: 00000 AND, 00001 XOR, 00010 ADD, 00011 OR, 00100 SLL, 00101 SRL, 00110 SUB, 00111 SRA, 01000 EQUAL, 01100 SLT (signed), 01101 SLTU, 10000 MUL, 10001 MULH, 10010 MULHSU, 10011 MULHU, 10100 DIV, 10101 DIVU, 10110 REM, 10111 REMU.
REQ-014 Undefined opcodes SHALL produce result 0 with single-op latency.
REQ-015 Shifts SHALL use only SrcB[$clog2(DATA_WIDTH)-1:0]; SRA SHALL sign-fill.
REQ-016 EQUAL/SLT/SLTU SHALL return 1 or 0, zero-extended; ADD/SUB/MUL SHALL wrap modulo 2^DATA_WIDTH.
REQ-017 MULH/MULHSU/MULHU SHALL return the upper DATA_WIDTH bits of the 2*DATA_WIDTH product (signed×signed, signed×unsigned, unsigned×unsigned).
REQ-018 Divide by zero SHALL give DIV/DIVU = all-ones, REM/REMU = SrcA.
REQ-019 Signed overflow (SrcA = most-negative, SrcB = -1) SHALL give DIV = SrcA, REM = 0.
REQ-020 A request SHALL be accepted on a rising edge where in_valid && in_ready; operands SHALL be captured then and later input changes ignored.
REQ-021 FSM states SHALL be IDLE, BUSY, DONE; in_ready SHALL be 1 only in IDLE.
REQ-022 IDLE + accept of single-cycle op, undefined op, or REQ-018/019 special case -> DONE; out_valid high the next cycle (latency 1).
REQ-023 IDLE + accept of other mul/div -> BUSY for exactly DATA_WIDTH cycles (one bit per cycle), then DONE; out_valid first high DATA_WIDTH+1 cycles after accept.
REQ-024 busy SHALL be 1 exactly in BUSY.
REQ-025 DONE SHALL hold ALUResult and out_valid stable until out_ready = 1; the edge with out_valid && out_ready SHALL return to IDLE.
REQ-026 No accept SHALL occur on the handshake edge leaving DONE; the next request is accepted no earlier than the following edge (max throughput one op per 2 cycles).
REQ-027 out_ready while not DONE SHALL be ignored; in_valid outside IDLE SHALL be ignored.

Reset
REQ-028 rst_n low SHALL asynchronously force IDLE, in_ready = 1 after release, out_valid = 0, busy = 0, ALUResult = 0, iteration counters and partial registers = 0.
REQ-029 Reset during BUSY or DONE SHALL abort the operation with no out_valid afterwards.

Structure
REQ-030 Opcode enum, FSM state enum and DATA_WIDTH-derived shift-width constant SHALL live in package alu_pkg.
REQ-031 The iterative shift-add multiplier / restoring divider SHALL be sub-module muldiv_iter (start, operands, sign controls, done, hi/lo results); single-cycle ops stay in alu_mc.

Verification
REQ-032 ADD 0x7FFFFFFF + 1, out_ready = 1 -> out_valid one cycle after accept, ALUResult 0x80000000.
REQ-033 SLT 0xFFFFFFFF vs 1 -> 1; SLTU same -> 0; SRA 0x80000000 by 0x24 -> 0xF8000000 (shift 4).
REQ-034 MULH 0xFFFFFFFF × 0xFFFFFFFF -> 0; MULHU same -> 0xFFFFFFFE; out_valid exactly 33 cycles after accept, busy high 32 cycles.
REQ-035 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 latency 1; DIVU 7/0 -> 0xFFFFFFFF; REM -7/2 -> 0xFFFFFFFF.
REQ-036 Result with out_ready low 5 cycles -> ALUResult and out_valid stable, in_ready 0 throughout; in_valid pulses meanwhile not accepted.
REQ-037 rst_n asserted at cycle 10 of a DIVU -> outputs reset immediately; next ADD 2+3 returns 5 normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode and FSM state encodings for the multi-cycle ALU,
// plus the helper that sizes the shift-amount field from the data width.
package alu_pkg;

    typedef enum logic [4:0] {
        OP_AND    = 5'b00000,
        OP_XOR    = 5'b00001,
        OP_ADD    = 5'b00010,
        OP_OR     = 5'b00011,
        OP_SLL    = 5'b00100,
        OP_SRL    = 5'b00101,
        OP_SUB    = 5'b00110,
        OP_SRA    = 5'b00111,
        OP_EQUAL  = 5'b01000,
        OP_SLT    = 5'b01100,
        OP_SLTU   = 5'b01101,
        OP_MUL    = 5'b10000,
        OP_MULH   = 5'b10001,
        OP_MULHSU = 5'b10010,
        OP_MULHU  = 5'b10011,
        OP_DIV    = 5'b10100,
        OP_DIVU   = 5'b10101,
        OP_REM    = 5'b10110,
        OP_REMU   = 5'b10111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    localparam int DEFAULT_DATA_WIDTH = 32;

    function automatic int shamt_width(input int data_width);
        return $clog2(data_width);
    endfunction

    localparam int SHAMT_W = shamt_width(DEFAULT_DATA_WIDTH);

endpackage

// File: rtl/muldiv_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle.
// Signed operands are reduced to magnitudes on start and the sign is restored on the way out.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             is_div_i,
    input  logic             a_signed_i,
    input  logic             b_signed_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic             active_q;
    logic             is_div_q;
    logic             neg_q;
    logic             rem_neg_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] b_q;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic             div_ge;
    logic [WIDTH-1:0] div_sub;
    logic [2*WIDTH-1:0] prod, prod_fix;

    assign a_neg = a_signed_i & a_i[WIDTH-1];
    assign b_neg = b_signed_i & b_i[WIDTH-1];
    assign a_mag = a_neg ? -a_i : a_i;
    assign b_mag = b_neg ? -b_i : b_i;

    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        div_sh  = {hi_q, lo_q[WIDTH-1]};
        div_ge  = (div_sh >= {1'b0, b_q});
        // When div_ge holds the difference is below b_q, so W bits are enough.
        div_sub = div_sh[WIDTH-1:0] - b_q;
        if (is_div_q) begin
            hi_d = div_ge ? div_sub : div_sh[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], div_ge};
        end else begin
            hi_d = mul_sum[WIDTH:1];
            lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    // Results are taken from the next-state values so the caller can latch them on the last step.
    always_comb begin
        prod     = {hi_d, lo_d};
        prod_fix = neg_q ? -prod : prod;
        if (is_div_q) begin
            hi_o = rem_neg_q ? -hi_d : hi_d;
            lo_o = neg_q ? -lo_d : lo_d;
        end else begin
            hi_o = prod_fix[2*WIDTH-1:WIDTH];
            lo_o = prod_fix[WIDTH-1:0];
        end
    end

    assign done_o = active_q && (cnt_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q  <= 1'b0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            b_q       <= '0;
        end else if (start_i) begin
            active_q  <= 1'b1;
            is_div_q  <= is_div_i;
            neg_q     <= a_neg ^ b_neg;
            rem_neg_q <= a_neg;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= a_mag;
            b_q       <= b_mag;
        end else if (active_q) begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q + 1'b1;
            if (done_o) begin
                active_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes: single-cycle ops and divide corner
// cases finish in one cycle, the remaining mul/div ops go through muldiv_iter.
module alu_mc
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    input  logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    ALUResult,
    output logic                     busy
);
    localparam int SHW = shamt_width(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    alu_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  sel_hi_q, sel_hi_d;

    logic [DATA_WIDTH-1:0] quick_res;
    logic                  needs_iter, iter_div, iter_a_signed, iter_b_signed, iter_sel_hi;
    logic                  div_by_zero, div_ovf;
    logic [SHW-1:0]        shamt;
    logic                  accept, md_start, md_done;
    logic [DATA_WIDTH-1:0] md_hi, md_lo;

    assign accept      = in_valid && (state_q == ST_IDLE);
    assign md_start    = accept && needs_iter;
    assign shamt       = SrcB[SHW-1:0];
    assign div_by_zero = (SrcB == '0);
    assign div_ovf     = (SrcA == MOST_NEG) && (SrcB == '1);

    always_comb begin
        quick_res     = '0;
        needs_iter    = 1'b0;
        iter_div      = 1'b0;
        iter_a_signed = 1'b0;
        iter_b_signed = 1'b0;
        iter_sel_hi   = 1'b0;
        case (Operation)
            OPCODE_LENGTH'(OP_AND):   quick_res = SrcA & SrcB;
            OPCODE_LENGTH'(OP_XOR):   quick_res = SrcA ^ SrcB;
            OPCODE_LENGTH'(OP_ADD):   quick_res = SrcA + SrcB;
            OPCODE_LENGTH'(OP_OR):    quick_res = SrcA | SrcB;
            OPCODE_LENGTH'(OP_SLL):   quick_res = SrcA << shamt;
            OPCODE_LENGTH'(OP_SRL):   quick_res = SrcA >> shamt;
            OPCODE_LENGTH'(OP_SUB):   quick_res = SrcA - SrcB;
            OPCODE_LENGTH'(OP_SRA):   quick_res = DATA_WIDTH'($signed(SrcA) >>> shamt);
            OPCODE_LENGTH'(OP_EQUAL): quick_res = DATA_WIDTH'(SrcA == SrcB);
            OPCODE_LENGTH'(OP_SLT):   quick_res = DATA_WIDTH'($signed(SrcA) < $signed(SrcB));
            OPCODE_LENGTH'(OP_SLTU):  quick_res = DATA_WIDTH'(SrcA < SrcB);
            OPCODE_LENGTH'(OP_MUL):   needs_iter = 1'b1;
            OPCODE_LENGTH'(OP_MULH): begin
                needs_iter    = 1'b1;
                iter_a_signed = 1'b1;
                iter_b_signed = 1'b1;
                iter_sel_hi   = 1'b1;
            end
            OPCODE_LENGTH'(OP_MULHSU): begin
                needs_iter    = 1'b1;
                iter_a_signed = 1'b1;
                iter_sel_hi   = 1'b1;
            end
            OPCODE_LENGTH'(OP_MULHU): begin
                needs_iter  = 1'b1;
                iter_sel_hi = 1'b1;
            end
            // Divide corner cases are resolved here so they keep single-cycle latency.
            OPCODE_LENGTH'(OP_DIV): begin
                if (div_by_zero)  quick_res = '1;
                else if (div_ovf) quick_res = SrcA;
                else begin
                    needs_iter    = 1'b1;
                    iter_div      = 1'b1;
                    iter_a_signed = 1'b1;
                    iter_b_signed = 1'b1;
                end
            end
            OPCODE_LENGTH'(OP_DIVU): begin
                if (div_by_zero) quick_res = '1;
                else begin
                    needs_iter = 1'b1;
                    iter_div   = 1'b1;
                end
            end
            OPCODE_LENGTH'(OP_REM): begin
                if (div_by_zero)  quick_res = SrcA;
                else if (div_ovf) quick_res = '0;
                else begin
                    needs_iter    = 1'b1;
                    iter_div      = 1'b1;
                    iter_a_signed = 1'b1;
                    iter_b_signed = 1'b1;
                    iter_sel_hi   = 1'b1;
                end
            end
            OPCODE_LENGTH'(OP_REMU): begin
                if (div_by_zero) quick_res = SrcA;
                else begin
                    needs_iter  = 1'b1;
                    iter_div    = 1'b1;
                    iter_sel_hi = 1'b1;
                end
            end
            default: quick_res = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        sel_hi_d = sel_hi_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    sel_hi_d = iter_sel_hi;
                    if (needs_iter) begin
                        state_d = ST_BUSY;
                    end else begin
                        state_d  = ST_DONE;
                        result_d = quick_res;
                    end
                end
            end
            ST_BUSY: begin
                if (md_done) begin
                    state_d  = ST_DONE;
                    result_d = sel_hi_q ? md_hi : md_lo;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            sel_hi_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            sel_hi_q <= sel_hi_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_BUSY);
    assign ALUResult = result_q;

    muldiv_iter #(
        .WIDTH(DATA_WIDTH)
    ) u_muldiv (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (md_start),
        .is_div_i  (iter_div),
        .a_signed_i(iter_a_signed),
        .b_signed_i(iter_b_signed),
        .a_i       (SrcA),
        .b_i       (SrcB),
        .done_o    (md_done),
        .hi_o      (md_hi),
        .lo_o      (md_lo)
    );

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed vector table, randomized ops against an
// arithmetic reference model, and hand-written stall / handshake / reset sequences.
module tb_alu_mc;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] SrcA = '0;
    logic [W-1:0] SrcB = '0;
    logic [4:0]   Operation = '0;
    logic         in_ready, out_valid, busy;
    logic [W-1:0] ALUResult;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_mc #(
        .DATA_WIDTH   (W),
        .OPCODE_LENGTH(5)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .SrcA     (SrcA),
        .SrcB     (SrcB),
        .Operation(Operation),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .ALUResult(ALUResult),
        .busy     (busy)
    );

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    localparam logic [4:0] VALID_OPS [19] = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06,
        5'h07, 5'h08, 5'h0C, 5'h0D, 5'h10, 5'h11, 5'h12, 5'h13, 5'h14, 5'h15, 5'h16, 5'h17};
    localparam logic [4:0] UNDEF_OPS [13] = '{5'h09, 5'h0A, 5'h0B, 5'h0E, 5'h0F, 5'h18, 5'h19,
        5'h1A, 5'h1B, 5'h1C, 5'h1D, 5'h1E, 5'h1F};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic void add_vec(input logic [4:0] op, input logic [31:0] a,
                                    input logic [31:0] b, input logic [31:0] exp, input int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.exp = exp; v.lat = lat;
        vecs.push_back(v);
    endfunction

    // Reference model: plain 64-bit arithmetic straight from the opcode definitions.
    function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        logic [31:0]     r;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'b0, a};
        ub = {32'b0, b};
        r  = '0;
        case (op)
            5'h00: r = a & b;
            5'h01: r = a ^ b;
            5'h02: r = a + b;
            5'h03: r = a | b;
            5'h04: r = a << b[4:0];
            5'h05: r = a >> b[4:0];
            5'h06: r = a - b;
            5'h07: begin p = sa >>> b[4:0]; r = p[31:0]; end
            5'h08: r = {31'b0, a == b};
            5'h0C: r = {31'b0, sa < sb};
            5'h0D: r = {31'b0, a < b};
            5'h10: begin p = ua * ub; r = p[31:0]; end
            5'h11: begin p = sa * sb; r = p[63:32]; end
            5'h12: begin p = sa * longint'(ub); r = p[63:32]; end
            5'h13: begin p = ua * ub; r = p[63:32]; end
            5'h14: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else begin p = sa / sb; r = p[31:0]; end
            end
            5'h15: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            5'h16: begin
                if (b == 0) r = a;
                else begin p = sa % sb; r = p[31:0]; end
            end
            5'h17: r = (b == 0) ? a : a % b;
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic int model_lat(input logic [4:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
        bit ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        if (op < 5'h10 || op > 5'h17) return 1;
        if (op >= 5'h14 && b == 0) return 1;
        if ((op == 5'h14 || op == 5'h16) && ovf) return 1;
        return W + 1;
    endfunction

    // Issue one request with out_ready high; returns result, cycles to out_valid, busy cycles.
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int bcnt,
                          output bit timeout);
        @(negedge clk);
        Operation = op; SrcA = a; SrcB = b; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; SrcA = $urandom; SrcB = $urandom; Operation = 5'($urandom);
        lat = 0; bcnt = 0; timeout = 1'b1;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (busy) bcnt++;
            if (out_valid) begin
                timeout = 1'b0;
                break;
            end
        end
        res = ALUResult;
        $display("op=%02h a=%08h b=%08h res=%08h lat=%0d busy=%0d", op, a, b, res, lat, bcnt);
        @(posedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] res, a, b;
        logic [4:0]  op;
        int          lat, bcnt, k;
        bit          to, saw;

        add_vec(5'h02, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1);
        add_vec(5'h0C, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1);
        add_vec(5'h0D, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1);
        add_vec(5'h07, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1);
        add_vec(5'h11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
        add_vec(5'h13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        add_vec(5'h14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        add_vec(5'h15, 32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF, 1);
        add_vec(5'h16, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33);
        add_vec(5'h17, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1);
        add_vec(5'h16, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
        add_vec(5'h10, 32'h0000_0003, 32'hFFFF_FFFD, 32'hFFFF_FFF7, 33);
        add_vec(5'h12, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 33);
        add_vec(5'h11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
        add_vec(5'h14, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33);
        add_vec(5'h15, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, 33);
        add_vec(5'h17, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 33);
        add_vec(5'h04, 32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 1);
        add_vec(5'h05, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 1);
        add_vec(5'h08, 32'h0000_0005, 32'h0000_0005, 32'h0000_0001, 1);
        add_vec(5'h09, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 1);
        add_vec(5'h06, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1);
        add_vec(5'h01, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1);
        add_vec(5'h03, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 1);
        add_vec(5'h00, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1);

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_result", ALUResult, 0);

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat, bcnt, to);
            check($sformatf("vec%0d_timeout", i), to, 0);
            check($sformatf("vec%0d_result", i), res, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("vec%0d_busy_cycles", i), bcnt, (vecs[i].lat == 1) ? 0 : W);
        end

        for (int n = 0; n < 30; n++) begin
            k = $urandom_range(0, 22);
            op = (k < 19) ? VALID_OPS[k] : UNDEF_OPS[$urandom_range(0, 12)];
            a = $urandom;
            b = $urandom;
            k = $urandom_range(0, 7);
            if (k == 0) b = 32'h0;
            else if (k == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (k == 2) b = $urandom_range(1, 15);
            run_op(op, a, b, res, lat, bcnt, to);
            check($sformatf("rand%0d_result", n), res, model(op, a, b));
            check($sformatf("rand%0d_latency", n), lat, model_lat(op, a, b));
        end

        // Result held with out_ready low; in_valid pulses must be ignored.
        @(negedge clk);
        Operation = 5'h02; SrcA = 32'd10; SrcB = 32'd20; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("stall_first_valid", out_valid, 1);
        check("stall_first_result", ALUResult, 32'd30);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0); Operation = 5'h06; SrcA = $urandom; SrcB = $urandom;
            @(negedge clk);
            check($sformatf("stall%0d_valid", i), out_valid, 1);
            check($sformatf("stall%0d_result", i), ALUResult, 32'd30);
            check($sformatf("stall%0d_in_ready", i), in_ready, 0);
            check($sformatf("stall%0d_busy", i), busy, 0);
        end
        in_valid = 1'b1; Operation = 5'h02; SrcA = 32'd1; SrcB = 32'd1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("handshake_no_accept_valid", out_valid, 0);
        check("handshake_in_ready", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("next_accept_valid", out_valid, 1);
        check("next_accept_result", ALUResult, 32'd2);
        @(posedge clk);

        // Reset in the middle of an iterative DIVU.
        @(negedge clk);
        Operation = 5'h15; SrcA = 32'd100; SrcB = 32'd7; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_busy_before", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_result", ALUResult, 0);
        check("abort_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) saw = 1'b1;
        end
        check("abort_no_late_valid", saw, 0);
        run_op(5'h02, 32'd2, 32'd3, res, lat, bcnt, to);
        check("post_reset_add_result", res, 32'd5);
        check("post_reset_add_latency", lat, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
